data_memory_dump: RTL
=====================

# data_memory_dump

Parametrised data memory for the processor's data path, the successor to the fixed 2048×16 data memory. It keeps the single-cycle write / registered-read CPU port and adds an independent dump read port. That port streams a configurable number of words, starting at address 0, to the debug unit over a valid/ready handshake. It sits between the execute stage's memory access and the debug/UART unit.

## Interface
- `DATA_WIDTH`, 16: word width in bits.
- `ADDR_WIDTH`, 11: address width in bits.
- `DEPTH`, 2048: number of words; must be ≤ 2^ADDR_WIDTH.
- `DUMP_WORDS`, DEPTH: words streamed per dump; 1..DEPTH.
- `clk`, in, 1: single clock, all state on rising edge.
- `rst`, in, 1: synchronous reset, active-high.
- `write`, in, 1: CPU write enable.
- `addr_data`, in, ADDR_WIDTH: CPU address.
- `in_data`, in, DATA_WIDTH: CPU write data.
- `out_data`, out, DATA_WIDTH: CPU read data, registered.
- `dump_start`, in, 1: request a dump; sampled in IDLE only.
- `dump_ready`, in, 1: debug unit accepts the current word.
- `dump_valid`, out, 1: `dump_data` / `dump_addr` are valid.
- `dump_data`, out, DATA_WIDTH: streamed word.
- `dump_addr`, out, ADDR_WIDTH: address of the streamed word.
- `dump_busy`, out, 1: high in every state except IDLE.
- `dump_done`, out, 1: one-cycle pulse after the last word is accepted.

## Operation
- **CPU write:** at the edge where `write=1` and `addr_data<DEPTH`, `mem[addr_data] <= in_data`. Writes to `addr_data≥DEPTH` are dropped.
- **CPU read:** every edge, `out_data <= mem[addr_data]`, or 0 if out of range.
  - Read-during-write to the same address is write-first: `out_data` takes `in_data`.
- **Memory contents** are not cleared by `rst`.
- **Dump FSM**, states IDLE, FETCH, SEND, DONE:
  - IDLE: when `dump_start=1`, set `cnt<=0` and go to FETCH.
  - FETCH: read `mem[cnt]` on the dump port; go to SEND. `dump_data` and `dump_addr` register at this edge.
  - SEND: `dump_valid=1`; outputs are held stable until `dump_ready=1`.
    - On ready with `cnt==DUMP_WORDS-1`: go to DONE.
    - On ready otherwise: `cnt<=cnt+1`, go to FETCH.
  - DONE: `dump_done=1` for one cycle, then go to IDLE.
- **Dump port** is read-first: the dump read in the same cycle as a CPU write to the same address returns the old value. CPU writes are never stalled by a dump.
- **Counter:** `cnt` is ADDR_WIDTH wide and never exceeds DUMP_WORDS-1; there is no wrap.
- **Ignored `dump_start`:** while busy, and in the DONE cycle, `dump_start` is ignored; only a start seen in IDLE begins a new dump.

## Timing
- **Reset values:** `out_data=0`, `dump_valid=0`, `dump_data=0`, `dump_addr=0`, `dump_busy=0`, `dump_done=0`, state IDLE, `cnt=0`.
- **CPU read latency:** 1 cycle; data addressed in cycle t is on `out_data` in cycle t+1.
- **Dump latency**, with `dump_start` high in cycle 0 and `dump_ready` held high:
  - word k is valid in cycle 2+2k;
  - `dump_done` is high in cycle 2·DUMP_WORDS+1;
  - `dump_busy` is high in cycles 1..2·DUMP_WORDS+1.
- **Backpressure:** each cycle `dump_ready=0` in SEND adds one cycle. `dump_data` / `dump_addr` must not change while `dump_valid=1` and `dump_ready=0`.
- **Reset mid-dump:** at the next edge, state goes to IDLE and all dump outputs go to 0. Memory and `out_data` follow reset rules; a CPU write in the reset cycle is still performed.

## Structure
- **Package `data_memory_pkg`:** state encoding (IDLE=2'd0, FETCH=2'd1, SEND=2'd2, DONE=2'd3) and default width/depth constants shared with the debug unit.
- **Sub-module `dual_port_ram`:** port A is write + write-first registered read; port B is a read-first registered read. It is parametrised by DATA_WIDTH / ADDR_WIDTH / DEPTH.
- **Top level:** FSM, counter and handshake registers.

## Test plan
- **CPU write/read:** write 1 at addr 0, 15 at addr 1, 20 at addr 32, then read each → `out_data` = 1, 15, 20, one cycle after the address is applied.
- **Read-during-write:** `write=1`, addr 5, data 0xABCD → `out_data=0xABCD` on the next cycle. Out-of-range write at addr DEPTH (with DEPTH=1024) → the read returns 0 and addr 0 is unchanged.
- **Full dump** (DUMP_WORDS=4, mem[0..3]=1,15,7,9, ready high) → `dump_data` 1,15,7,9 at cycles 2,4,6,8 with `dump_addr` 0..3; `dump_done` at cycle 9; then IDLE.
- **Backpressure:** drop `dump_ready` for 3 cycles on word 1 → `dump_data=15` and `dump_addr=1` held stable; `dump_done` is delayed by 3 cycles.
- **Concurrent write during dump:** CPU writes 0x55 to addr 2 in the same cycle the FSM is in FETCH for cnt=2 → dump emits the old value 7; a later CPU read of addr 2 returns 0x55. A `dump_start` pulse mid-dump is ignored.
- **Reset mid-dump:** assert `rst` during SEND of word 2 → next cycle all dump outputs are 0 and `dump_busy=0`. A new `dump_start` restarts the dump at addr 0, and memory contents are intact.

Source files
------------

// File: rtl/data_memory_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_pkg
//
// Purpose : Shared definitions for the parametrised data memory and the
//           debug/UART unit that consumes its dump stream. Holds the dump FSM
//           state encoding, the default geometry of the memory and a small
//           helper for sizing the internal array index.
//
// Contents: DEFAULT_DATA_WIDTH / DEFAULT_ADDR_WIDTH / DEFAULT_DEPTH
//           dumpState_e    - dump FSM states (IDLE, FETCH, SEND, DONE)
//           indexWidth()   - bits needed to index an array of 'depth' words
// -----------------------------------------------------------------------------
package data_memory_pkg;

  // Default geometry, matching the original fixed 2048 x 16 data memory so the
  // debug unit can size its receive path from the same constants.
  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 11;
  localparam int DEFAULT_DEPTH      = 2048;

  // Dump FSM encoding. The values are fixed because the debug unit decodes
  // them when it samples the state for diagnostics.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } dumpState_e;

  // Width of the index into the storage array. A single-word memory still
  // needs a one-bit index so that slices never collapse to zero width.
  function automatic int indexWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dual_port_ram.sv
// -----------------------------------------------------------------------------
// dual_port_ram
//
// Purpose : Storage for the data memory. Port A belongs to the CPU and does a
//           single-cycle write plus a registered, write-first read. Port B is
//           a registered, read-first read used by the dump engine; it only
//           updates when enabled so the word it presents stays put while the
//           debug unit applies backpressure.
//
// Ports   : clk_i      - clock, all state on the rising edge
//           rst_i      - synchronous active-high reset of the read registers
//                        (the storage array itself is never cleared)
//           weA_i      - port A write enable
//           addrA_i    - port A address
//           wdataA_i   - port A write data
//           rdataA_o   - port A registered read data
//           enB_i      - port B read enable
//           addrB_i    - port B address
//           rdataB_o   - port B registered read data
// -----------------------------------------------------------------------------
module dual_port_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH      = 2048
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  weA_i,
  input  logic [ADDR_WIDTH-1:0] addrA_i,
  input  logic [DATA_WIDTH-1:0] wdataA_i,
  output logic [DATA_WIDTH-1:0] rdataA_o,
  input  logic                  enB_i,
  input  logic [ADDR_WIDTH-1:0] addrB_i,
  output logic [DATA_WIDTH-1:0] rdataB_o
);

  import data_memory_pkg::*;

  localparam int IdxW = indexWidth(DEPTH);

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable in the compare.
  localparam logic [ADDR_WIDTH:0] DepthW = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  inRangeA;
  logic                  inRangeB;
  logic [IdxW-1:0]       idxA;
  logic [IdxW-1:0]       idxB;
  logic [DATA_WIDTH-1:0] rdataA_q;
  logic [DATA_WIDTH-1:0] rdataB_q;

  // Addresses at or above DEPTH have no storage behind them: writes are
  // dropped and reads return zero. The narrowed index is only used once the
  // range check has passed.
  assign inRangeA = ({1'b0, addrA_i} < DepthW);
  assign inRangeB = ({1'b0, addrB_i} < DepthW);
  assign idxA     = addrA_i[IdxW-1:0];
  assign idxB     = addrB_i[IdxW-1:0];

  // Storage array. Deliberately outside the reset domain: a reset of the
  // processor must not wipe data memory, and a write issued in the same cycle
  // as reset still lands.
  always_ff @(posedge clk_i) begin
    if (weA_i && inRangeA) begin
      mem[idxA] <= wdataA_i;
    end
  end

  // CPU read register. Write-first: when the CPU writes and reads the same
  // address in one cycle it sees the new data, without waiting for the array.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdataA_q <= '0;
    end else if (!inRangeA) begin
      rdataA_q <= '0;
    end else if (weA_i) begin
      rdataA_q <= wdataA_i;
    end else begin
      rdataA_q <= mem[idxA];
    end
  end

  // Dump read register. Read-first: it samples the array before any CPU write
  // on the same edge takes effect, so a concurrent write is never stalled and
  // the dump sees the value that was stored when it fetched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdataB_q <= '0;
    end else if (enB_i) begin
      rdataB_q <= inRangeB ? mem[idxB] : '0;
    end
  end

  assign rdataA_o = rdataA_q;
  assign rdataB_o = rdataB_q;

endmodule

// File: rtl/data_memory_dump.sv
// -----------------------------------------------------------------------------
// data_memory_dump
//
// Purpose : Parametrised data memory for the processor data path. The CPU port
//           keeps single-cycle writes and a one-cycle registered read. A dump
//           engine streams words 0 .. DUMP_WORDS-1 to the debug unit over a
//           valid/ready handshake, independently of CPU traffic.
//
// Ports   : clk        - clock, all state on the rising edge
//           rst        - synchronous active-high reset (memory is kept)
//           write      - CPU write enable
//           addr_data  - CPU address
//           in_data    - CPU write data
//           out_data   - CPU read data, registered
//           dump_start - request a dump (only honoured while idle)
//           dump_ready - debug unit accepts the presented word
//           dump_valid - dump_data / dump_addr hold a word
//           dump_data  - streamed word
//           dump_addr  - address of the streamed word
//           dump_busy  - a dump is in progress (any state except IDLE)
//           dump_done  - one-cycle pulse after the last word is accepted
// -----------------------------------------------------------------------------
module data_memory_dump
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int DUMP_WORDS = DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr_data,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  dump_start,
  input  logic                  dump_ready,
  output logic                  dump_valid,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic                  dump_busy,
  output logic                  dump_done
);

  // Index of the final word of a dump; the counter stops here, never wraps.
  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(DUMP_WORDS - 1);

  dumpState_e            state_q;
  dumpState_e            state_d;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] cnt_d;
  logic [ADDR_WIDTH-1:0] dumpAddr_q;
  logic [ADDR_WIDTH-1:0] dumpAddr_d;
  logic                  dumpRdEn;

  // Port A serves the CPU, port B is driven by the dump engine. Port B's read
  // register is the dump_data output, so it only advances on a FETCH and holds
  // its word for as long as the debug unit keeps dump_ready low.
  dual_port_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk_i    (clk),
    .rst_i    (rst),
    .weA_i    (write),
    .addrA_i  (addr_data),
    .wdataA_i (in_data),
    .rdataA_o (out_data),
    .enB_i    (dumpRdEn),
    .addrB_i  (cnt_q),
    .rdataB_o (dump_data)
  );

  // State, word counter and the address that accompanies the streamed word.
  // Reset drops any dump in flight and clears everything the debug unit sees.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dumpAddr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dumpAddr_q <= dumpAddr_d;
    end
  end

  // Next-state logic. Each word costs a FETCH (array read into the output
  // register) and at least one SEND (presented until accepted). dump_start is
  // only looked at in IDLE, so pulses during a dump or in the DONE cycle are
  // dropped rather than queued.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dumpAddr_d = dumpAddr_q;
    dumpRdEn   = 1'b0;

    case (state_q)
      IDLE: begin
        if (dump_start) begin
          cnt_d   = '0;
          state_d = FETCH;
        end
      end

      FETCH: begin
        dumpRdEn   = 1'b1;
        dumpAddr_d = cnt_q;
        state_d    = SEND;
      end

      SEND: begin
        if (dump_ready) begin
          if (cnt_q == LastIdx) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + ADDR_WIDTH'(1);
            state_d = FETCH;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs are decoded straight from the registered state, so they
  // are glitch-free and drop to zero on the edge that applies reset.
  always_comb begin
    dump_valid = (state_q == SEND);
    dump_busy  = (state_q != IDLE);
    dump_done  = (state_q == DONE);
  end

  assign dump_addr = dumpAddr_q;

endmodule
